regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file serving both the integer (x0 hardwired to zero) and floating-point (f0 writable) register banks of the RISC-V core. It provides `NR` asynchronous read ports and `NW` synchronous write ports. Same-cycle write-to-read bypass is optional. A per-entry scoreboard (pending bit) tracks in-flight writes. A hardware zeroing sweep runs after reset or on request, and `ready_o` stays low until the sweep completes. Decode reads it; the writeback stage and the issue stage drive it.

## Interface
- `XLEN`, 32, data width per register
- `DEPTH`, 32, number of registers; power of two, ≥ 2; `AW = $clog2(DEPTH)` is derived, not overridable
- `NR`, 3, read ports (3 covers FMA `rs3`)
- `NW`, 2, write ports
- `ZERO_REG`, 1, 1: entry 0 reads 0, ignores writes, never goes pending; 0: entry 0 is an ordinary register
- `BYPASS`, 1, 1: read ports see same-cycle write data; 0: read ports see stored data only
- `clk_i`  in  1  clock, all state updates on rising edge
- `rst_ni`  in  1  reset, asynchronous assert, active-low
- `init_i`  in  1  start a zeroing sweep
- `ready_o`  out  1  high when the sweep is done and the file accepts traffic
- `rs_addr_i`  in  `NR*AW`  read addresses; port k is bits `[k*AW +: AW]`
- `rs_data_o`  out  `NR*XLEN`  read data, packed the same way
- `pend_o`  out  `NR`  pending bit for each read address
- `rd_addr_i`  in  `NW*AW`  write addresses
- `rd_data_i`  in  `NW*XLEN`  write data
- `rd_wren_i`  in  `NW`  write enables; a write also clears the pending bit of its address
- `sb_set_i`  in  1  mark `sb_addr_i` pending (instruction issued)
- `sb_addr_i`  in  `AW`  scoreboard set address

## Operation
- FSM has two states: `INIT` and `READY`. Sweep counter `cnt` is `AW+1` bits wide.
- Reset (async, `rst_ni`=0):
  - state=`INIT`, `cnt`=0, all pending bits=0, `ready_o`=0.
  - Storage is not reset. The sweep zeroes it.
- `INIT`:
  - Each edge writes 0 to `mem[cnt]` and increments `cnt`.
  - After `mem[DEPTH-1]` is written, state becomes `READY`.
  - Write ports and `sb_set_i` are ignored.
  - `rs_data_o`=0 and `pend_o`=0 on every port.
- `init_i`=1:
  - In `READY`: next edge goes to `INIT`, sets `cnt`=0 and clears all pending bits. Writes in that same cycle are dropped.
  - In `INIT`: `cnt` restarts at 0.
- Write (`READY`):
  - For each port j with `rd_wren_i[j]`=1, `mem[addr_j] <= data_j` and `pend[addr_j] <= 0`.
  - If several ports target the same address, the highest-index port wins.
  - When `ZERO_REG`=1, writes to address 0 are discarded.
- Scoreboard set: `sb_set_i`=1 sets `pend[sb_addr_i] <= 1`.
  - A set to the same address as a same-cycle write wins over the write's clear. The data write still happens.
  - When `ZERO_REG`=1, a set to address 0 is ignored.
- Read (combinational, `READY`), port k at address a:
  - If `ZERO_REG`=1 and a=0: `rs_data_o`=0 and `pend_o`=0.
  - Else if `BYPASS`=1 and a matching write is enabled this cycle: the data of the highest-index matching port, and `pend_o[k]`=0.
  - Otherwise: `mem[a]` and `pend[a]`.
  - A same-cycle `sb_set_i` is never visible on `pend_o` before the edge.

## Timing
- Read latency is 0 cycles (combinational from `rs_addr_i`). Write latency is 1 edge. With `BYPASS`=1, written data is visible on reads in the same cycle.
- `ready_o` is registered. It rises exactly `DEPTH` rising edges after `rst_ni` deasserts, or after the edge that samples `init_i`.
  - In both cases it rises in the cycle following the edge that writes `mem[DEPTH-1]`.
- `ready_o` falls on the edge that samples `init_i`, or asynchronously on reset.
- Reset during a sweep aborts it. The sweep restarts from entry 0 after release.

## Test plan
- **Reset sweep, default parameters:** release `rst_ni`. Require `ready_o`=0 for 32 edges, then 1. All 32 reads return 0x0 and `pend_o`=0.
- **Port conflict and bypass (`BYPASS`=1):**
  - Write port 0 puts 0xDEADBEEF to x5 and port 1 puts 0x12345678 to x5 in the same cycle, with `rs_addr` port 2=5.
  - Require a same-cycle read of 0x12345678 and 0x12345678 stored after the edge.
  - With `BYPASS`=0, the same-cycle read returns the old value 0x0.
- **Zero register:**
  - `ZERO_REG`=1: write 0xFFFFFFFF to x0 and `sb_set` x0. Require reads of 0 and pend 0.
  - `ZERO_REG`=0: the same stimulus reads 0xFFFFFFFF after the write.
- **Scoreboard:**
  - `sb_set` x7; next cycle `pend_o`=1 on the port reading x7.
  - Write x7 = 0xA5 with `sb_set` x7 in the same cycle. Require data 0xA5 and pend still 1.
  - Write x7 alone. Require pend 0 in the same cycle (bypass) and after the edge.
- **Re-init:**
  - In `READY`, with x3 = 0x55 and x3 pending, pulse `init_i` together with a write of x4 = 0x66.
  - Require `ready_o`=0 next cycle and the x4 write dropped.
  - Require 32 cycles until ready, after which x3 = x4 = 0 and pend = 0.
- **Reset mid-sweep:** assert `rst_ni` after 10 sweep edges and release it. Require `ready_o` exactly 32 edges after release, and no writes or sets accepted during `INIT`.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp. It carries the read ports, the write ports, the scoreboard set
// and the init/ready handshake. The register file sits on the slave side.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NR    = 3,
  parameter int NW    = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                 init_i;
  logic                 ready_o;
  logic [NR*AW-1:0]     rs_addr_i;
  logic [NR*XLEN-1:0]   rs_data_o;
  logic [NR-1:0]        pend_o;
  logic [NW*AW-1:0]     rd_addr_i;
  logic [NW*XLEN-1:0]   rd_data_i;
  logic [NW-1:0]        rd_wren_i;
  logic                 sb_set_i;
  logic [AW-1:0]        sb_addr_i;

  modport master (
    output init_i, rs_addr_i, rd_addr_i, rd_data_i, rd_wren_i, sb_set_i, sb_addr_i,
    input  ready_o, rs_data_o, pend_o
  );

  modport slave (
    input  init_i, rs_addr_i, rd_addr_i, rd_data_i, rd_wren_i, sb_set_i, sb_addr_i,
    output ready_o, rs_data_o, pend_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-write scoreboard, an optional hardwired-zero entry 0,
// optional same-cycle write bypass, and a zeroing sweep after reset or on request.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 3,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  regfile_mp_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LAST_IDX  = (AW+1)'(DEPTH-1);
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic        ZR_EN     = (ZERO_REG != 0);
  localparam logic        BP_EN     = (BYPASS != 0);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_r;
  logic [AW:0]         cnt_r;
  logic                ready_r;
  logic [DEPTH-1:0]    pend_r;
  logic [DEPTH-1:0]    pend_nxt_s;
  logic [XLEN-1:0]     mem_r [DEPTH];

  logic                accept_s;
  logic [NW-1:0]       wr_ok_s;
  logic                sb_ok_s;
  logic [NR*XLEN-1:0]  rs_data_s;
  logic [NR-1:0]       pend_s;
  logic [AW-1:0]       rd_a_s;
  logic [XLEN-1:0]     rd_d_s;
  logic                hit_s;
  logic                match_s;

  // Qualify writes and scoreboard sets. Only traffic in READY, with no init request, is accepted.
  always_comb begin
    accept_s = (state_r == ST_READY) && !bus.init_i;
    wr_ok_s  = {NW{1'b0}};
    for (int j = 0; j < NW; j++) begin
      wr_ok_s[j] = accept_s && bus.rd_wren_i[j] &&
                   !(ZR_EN && (bus.rd_addr_i[j*AW +: AW] == ADDR_ZERO));
    end
    sb_ok_s = accept_s && bus.sb_set_i && !(ZR_EN && (bus.sb_addr_i == ADDR_ZERO));
  end

  // Next pending vector. Writes clear their bit first, so a same-cycle set overrides the clear.
  always_comb begin
    pend_nxt_s = pend_r;
    for (int j = 0; j < NW; j++) begin
      pend_nxt_s[bus.rd_addr_i[j*AW +: AW]] =
        wr_ok_s[j] ? 1'b0 : pend_nxt_s[bus.rd_addr_i[j*AW +: AW]];
    end
    pend_nxt_s[bus.sb_addr_i] = sb_ok_s ? 1'b1 : pend_nxt_s[bus.sb_addr_i];
  end

  // Sweep sequencer with the registered ready flag and the scoreboard bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_INIT;
      cnt_r   <= CNT_ZERO;
      ready_r <= 1'b0;
      pend_r  <= {DEPTH{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          if (bus.init_i) begin
            cnt_r <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == LAST_IDX) begin
              state_r <= ST_READY;
              ready_r <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (bus.init_i) begin
            state_r <= ST_INIT;
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b0;
            pend_r  <= {DEPTH{1'b0}};
          end else begin
            pend_r  <= pend_nxt_s;
          end
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= CNT_ZERO;
          ready_r <= 1'b0;
          pend_r  <= {DEPTH{1'b0}};
        end
      endcase
    end
  end

  // Storage is not reset. The sweep zeroes one entry per edge. Later ports are assigned last and so win conflicts.
  always_ff @(posedge clk_i) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r[AW-1:0]] <= {XLEN{1'b0}};
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_ok_s[j]) begin
          mem_r[bus.rd_addr_i[j*AW +: AW]] <= bus.rd_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read ports with optional bypass from accepted same-cycle writes.
  always_comb begin
    rs_data_s = {(NR*XLEN){1'b0}};
    pend_s    = {NR{1'b0}};
    rd_a_s    = ADDR_ZERO;
    rd_d_s    = {XLEN{1'b0}};
    hit_s     = 1'b0;
    match_s   = 1'b0;
    for (int k = 0; k < NR; k++) begin
      rd_a_s = bus.rs_addr_i[k*AW +: AW];
      rd_d_s = mem_r[rd_a_s];
      hit_s  = 1'b0;
      for (int j = 0; j < NW; j++) begin
        match_s = BP_EN && wr_ok_s[j] && (bus.rd_addr_i[j*AW +: AW] == rd_a_s);
        rd_d_s  = match_s ? bus.rd_data_i[j*XLEN +: XLEN] : rd_d_s;
        hit_s   = hit_s | match_s;
      end
      if ((state_r != ST_READY) || (ZR_EN && (rd_a_s == ADDR_ZERO))) begin
        rs_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
        pend_s[k]                 = 1'b0;
      end else begin
        rs_data_s[k*XLEN +: XLEN] = rd_d_s;
        pend_s[k]                 = pend_r[rd_a_s] & ~hit_s;
      end
    end
  end

  assign bus.ready_o   = ready_r;
  assign bus.rs_data_o = rs_data_s;
  assign bus.pend_o    = pend_s;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. Two instances share the stimulus: A has the zero register and bypass
// enabled, B has neither. Both are checked against an array-based reference model.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 3;
  localparam int NW    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic                clk_i;
  logic                rst_ni;
  logic                init_s;
  logic [NR*AW-1:0]    rs_addr_s;
  logic [NW*AW-1:0]    rd_addr_s;
  logic [NW*XLEN-1:0]  rd_data_s;
  logic [NW-1:0]       rd_wren_s;
  logic                sb_set_s;
  logic [AW-1:0]       sb_addr_s;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = instance A (zero reg + bypass), 1 = instance B (plain).
  logic [XLEN-1:0]  m_mem [2][DEPTH];
  logic [DEPTH-1:0] m_pend [2];
  bit               m_ready;
  int               m_left;

  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus_a ();
  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW)) bus_b ();

  assign bus_a.init_i = init_s;    assign bus_b.init_i = init_s;
  assign bus_a.rs_addr_i = rs_addr_s; assign bus_b.rs_addr_i = rs_addr_s;
  assign bus_a.rd_addr_i = rd_addr_s; assign bus_b.rd_addr_i = rd_addr_s;
  assign bus_a.rd_data_i = rd_data_s; assign bus_b.rd_data_i = rd_data_s;
  assign bus_a.rd_wren_i = rd_wren_s; assign bus_b.rd_wren_i = rd_wren_s;
  assign bus_a.sb_set_i = sb_set_s;   assign bus_b.sb_set_i = sb_set_s;
  assign bus_a.sb_addr_i = sb_addr_s; assign bus_b.sb_addr_i = sb_addr_s;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1))
    dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_a));
  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(0), .BYPASS(0))
    dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus_b));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [XLEN-1:0] got_d(int c, int k);
    return (c == 0) ? bus_a.rs_data_o[k*XLEN +: XLEN] : bus_b.rs_data_o[k*XLEN +: XLEN];
  endfunction
  function automatic logic got_p(int c, int k);
    return (c == 0) ? bus_a.pend_o[k] : bus_b.pend_o[k];
  endfunction
  function automatic logic got_r(int c);
    return (c == 0) ? bus_a.ready_o : bus_b.ready_o;
  endfunction

  // Expected read data. Instance A has the zero register and bypass.
  function automatic logic [XLEN-1:0] exp_d(int c, int k);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    a = rs_addr_s[k*AW +: AW];
    if (!m_ready || (c == 0 && a == 0)) return '0;
    d = m_mem[c][a];
    if (c == 0 && !init_s)
      for (int j = 0; j < NW; j++)
        if (rd_wren_s[j] && rd_addr_s[j*AW +: AW] == a) d = rd_data_s[j*XLEN +: XLEN];
    return d;
  endfunction

  function automatic logic exp_p(int c, int k);
    logic [AW-1:0] a;
    logic          p;
    a = rs_addr_s[k*AW +: AW];
    if (!m_ready || (c == 0 && a == 0)) return 1'b0;
    p = m_pend[c][a];
    if (c == 0 && !init_s)
      for (int j = 0; j < NW; j++)
        if (rd_wren_s[j] && rd_addr_s[j*AW +: AW] == a) p = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = DEPTH;
    m_pend[0] = '0;
    m_pend[1] = '0;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    logic [AW-1:0] a;
    if (!m_ready) begin
      if (init_s) m_left = DEPTH;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_ready = 1'b1;
          for (int c = 0; c < 2; c++) for (int i = 0; i < DEPTH; i++) m_mem[c][i] = '0;
        end
      end
    end else if (init_s) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
      m_pend[0] = '0;
      m_pend[1] = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int j = 0; j < NW; j++) begin
          a = rd_addr_s[j*AW +: AW];
          if (rd_wren_s[j] && !(c == 0 && a == 0)) begin
            m_mem[c][a]  = rd_data_s[j*XLEN +: XLEN];
            m_pend[c][a] = 1'b0;
          end
        end
        if (sb_set_s && !(c == 0 && sb_addr_s == 0)) m_pend[c][sb_addr_s] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    init_s    = 1'b0;
    rd_addr_s = '0;
    rd_data_s = '0;
    rd_wren_s = '0;
    sb_set_s  = 1'b0;
    sb_addr_s = '0;
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
  endfunction

  task automatic drive_random(bit allow_init);
    for (int j = 0; j < NW; j++) begin
      rd_addr_s[j*AW +: AW]   = raddr();
      rd_data_s[j*XLEN +: XLEN] = $urandom;
    end
    for (int k = 0; k < NR; k++) rs_addr_s[k*AW +: AW] = raddr();
    rd_wren_s = NW'($urandom);
    sb_set_s  = 1'($urandom);
    sb_addr_s = raddr();
    init_s    = allow_init && ($urandom_range(0, 99) == 0);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_idle();
    rs_addr_s = '0;
    model_reset();
    #12;
    rst_ni = 1'b1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_r(c) !== 1'b0) begin errors++; $display("FAIL reset_ready cfg%0d: got %b expected 0", c, got_r(c)); end
    end
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      for (int k = 0; k < NR; k++) rs_addr_s[k*AW +: AW] = AW'($urandom);
      #1;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (got_r(c) !== (e == DEPTH)) begin
          errors++; $display("FAIL sweep_ready cfg%0d edge%0d: got %b expected %b", c, e, got_r(c), e == DEPTH);
        end
        for (int k = 0; k < NR; k++) begin
          checks++;
          if (got_d(c, k) !== exp_d(c, k) || got_p(c, k) !== exp_p(c, k)) begin
            errors++; $display("FAIL sweep_read cfg%0d port%0d: got %h/%b expected %h/%b", c, k, got_d(c, k), got_p(c, k), exp_d(c, k), exp_p(c, k));
          end
        end
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      rs_addr_s = {NR{AW'(a)}};
      #1;
      for (int c = 0; c < 2; c++) for (int k = 0; k < NR; k++) begin
        checks++;
        if (got_d(c, k) !== 32'h0 || got_p(c, k) !== 1'b0) begin
          errors++; $display("FAIL zeroed cfg%0d addr%0d: got %h/%b expected 0/0", c, a, got_d(c, k), got_p(c, k));
        end
      end
      tick();
    end
  endtask

  task automatic test_conflict();
    drive_idle();
    rd_addr_s = {5'd5, 5'd5};
    rd_data_s = {32'h12345678, 32'hDEADBEEF};
    rd_wren_s = 2'b11;
    rs_addr_s = {5'd5, 5'd1, 5'd2};
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_d(c, 2) !== exp_d(c, 2)) begin
        errors++; $display("FAIL conflict_same_cycle cfg%0d: got %h expected %h", c, got_d(c, 2), exp_d(c, 2));
      end
    end
    tick();
    drive_idle();
    rs_addr_s = {NR{5'd5}};
    #1;
    for (int c = 0; c < 2; c++) for (int k = 0; k < NR; k++) begin
      checks++;
      if (got_d(c, k) !== 32'h12345678 || got_p(c, k) !== exp_p(c, k)) begin
        errors++; $display("FAIL conflict_stored cfg%0d port%0d: got %h/%b expected 12345678/%b", c, k, got_d(c, k), got_p(c, k), exp_p(c, k));
      end
    end
    tick();
  endtask

  task automatic test_zero();
    drive_idle();
    rd_addr_s = '0;
    rd_data_s[XLEN-1:0] = 32'hFFFFFFFF;
    rd_wren_s = 2'b01;
    sb_set_s  = 1'b1;
    sb_addr_s = '0;
    rs_addr_s = '0;
    tick();
    drive_idle();
    #1;
    for (int c = 0; c < 2; c++) for (int k = 0; k < NR; k++) begin
      checks++;
      if (got_d(c, k) !== exp_d(c, k) || got_p(c, k) !== exp_p(c, k)) begin
        errors++; $display("FAIL zero_reg cfg%0d port%0d: got %h/%b expected %h/%b", c, k, got_d(c, k), got_p(c, k), exp_d(c, k), exp_p(c, k));
      end
    end
    tick();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    sb_set_s  = 1'b1;
    sb_addr_s = 5'd7;
    rs_addr_s = {NR{5'd7}};
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_p(c, 0) !== 1'b0) begin errors++; $display("FAIL sb_early cfg%0d: got %b expected 0", c, got_p(c, 0)); end
    end
    tick();
    sb_set_s = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_p(c, 1) !== exp_p(c, 1)) begin errors++; $display("FAIL sb_set cfg%0d: got %b expected %b", c, got_p(c, 1), exp_p(c, 1)); end
    end
    rd_addr_s[AW-1:0] = 5'd7;
    rd_data_s[XLEN-1:0] = 32'h000000A5;
    rd_wren_s = 2'b01;
    sb_set_s  = 1'b1;
    tick();
    drive_idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_d(c, 0) !== exp_d(c, 0) || got_p(c, 0) !== exp_p(c, 0)) begin
        errors++; $display("FAIL sb_set_wins cfg%0d: got %h/%b expected %h/%b", c, got_d(c, 0), got_p(c, 0), exp_d(c, 0), exp_p(c, 0));
      end
    end
    rd_addr_s[AW-1:0] = 5'd7;
    rd_data_s[XLEN-1:0] = 32'h0000005A;
    rd_wren_s = 2'b01;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_d(c, 2) !== exp_d(c, 2) || got_p(c, 2) !== exp_p(c, 2)) begin
        errors++; $display("FAIL sb_clear_bypass cfg%0d: got %h/%b expected %h/%b", c, got_d(c, 2), got_p(c, 2), exp_d(c, 2), exp_p(c, 2));
      end
    end
    tick();
    drive_idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_d(c, 1) !== exp_d(c, 1) || got_p(c, 1) !== exp_p(c, 1)) begin
        errors++; $display("FAIL sb_clear cfg%0d: got %h/%b expected %h/%b", c, got_d(c, 1), got_p(c, 1), exp_d(c, 1), exp_p(c, 1));
      end
    end
    tick();
  endtask

  task automatic test_reinit();
    int n;
    drive_idle();
    rd_addr_s = {5'd3, 5'd0};
    rd_data_s = {32'h00000055, 32'h0};
    rd_wren_s = 2'b10;
    sb_set_s  = 1'b1;
    sb_addr_s = 5'd3;
    tick();
    drive_idle();
    init_s    = 1'b1;
    rd_addr_s[AW-1:0] = 5'd4;
    rd_data_s[XLEN-1:0] = 32'h00000066;
    rd_wren_s = 2'b01;
    rs_addr_s = {5'd3, 5'd4, 5'd3};
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_p(c, 0) !== 1'b1 || got_d(c, 1) !== exp_d(c, 1)) begin
        errors++; $display("FAIL reinit_pre cfg%0d: got pend %b x4 %h expected pend 1 x4 %h", c, got_p(c, 0), got_d(c, 1), exp_d(c, 1));
      end
    end
    tick();
    drive_idle();
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_r(c) !== 1'b0) begin errors++; $display("FAIL reinit_ready_low cfg%0d: got %b expected 0", c, got_r(c)); end
    end
    n = 0;
    while (got_r(0) !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL reinit_latency: got %0d edges expected %0d", n, DEPTH); end
    #1;
    for (int c = 0; c < 2; c++) for (int k = 0; k < NR; k++) begin
      checks++;
      if (got_r(c) !== 1'b1 || got_d(c, k) !== 32'h0 || got_p(c, k) !== 1'b0) begin
        errors++; $display("FAIL reinit_cleared cfg%0d port%0d: got rdy %b %h/%b expected 1 0/0", c, k, got_r(c), got_d(c, k), got_p(c, k));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    drive_idle();
    init_s = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin drive_random(1'b0); tick(); end
    drive_idle();
    rst_ni = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (got_r(c) !== 1'b0) begin errors++; $display("FAIL midreset_ready cfg%0d: got %b expected 0", c, got_r(c)); end
    end
    #1;
    rst_ni = 1'b1;
    n = 0;
    while (got_r(0) !== 1'b1 && n < 40) begin drive_random(1'b0); tick(); n++; end
    drive_idle();
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL midreset_latency: got %0d edges expected %0d", n, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      rs_addr_s = {NR{AW'(a)}};
      #1;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (got_d(c, 0) !== 32'h0 || got_p(c, 0) !== 1'b0) begin
          errors++; $display("FAIL midreset_clean cfg%0d addr%0d: got %h/%b expected 0/0", c, a, got_d(c, 0), got_p(c, 0));
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_random(1'b1);
      #1;
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (got_r(c) !== m_ready) begin errors++; $display("FAIL rand_ready cfg%0d it%0d: got %b expected %b", c, i, got_r(c), m_ready); end
        for (int k = 0; k < NR; k++) begin
          checks++;
          if (got_d(c, k) !== exp_d(c, k) || got_p(c, k) !== exp_p(c, k)) begin
            errors++; $display("FAIL rand_read cfg%0d it%0d port%0d: got %h/%b expected %h/%b", c, i, k, got_d(c, k), got_p(c, k), exp_d(c, k), exp_p(c, k));
          end
        end
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    rs_addr_s = '0;
    test_reset();
    test_conflict();
    test_zero();
    test_scoreboard();
    test_reinit();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
